mc_ctrl: RTL and testbench

//  Multi-cycle MIPS control unit; successor to the single-cycle signal generator.

---
 rtl/mc_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control unit sequencing FETCH/DECODE/EXEC/MEM/WB, with TRAP.
// Latency: all outputs are combinational from the state register plus op/funct/zero/mem_rdy.
// Backpressure: FETCH and MEM hold while mem_rdy is low; a watchdog traps after WDT waits.
// Ports: clk, rst_n (async, active low); op/funct/zero from IR and ALU; mem_rdy from memory;
//   mem_*/iord/ir_we/pc_*/reg_*/alu_*/imm_ext drive the datapath; trap/trap_code/state report status.
// Option: define MC_CTRL_PERF_EN to add cyc_cnt/ret_cnt performance counters.
module mc_ctrl #(
  parameter int ALUOP_W = 3,
  parameter int WDT     = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_rdy,
  output logic               mem_req,
  output logic               mem_we,
  output logic [1:0]         mem_size,
  output logic               mem_ext,
  output logic               iord,
  output logic               ir_we,
  output logic               pc_we,
  output logic [1:0]         pc_src,
  output logic               reg_we,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_srcA,
  output logic [1:0]         alu_srcB,
  output logic               imm_ext,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               trap,
  output logic [1:0]         trap_code,
  output logic [2:0]         state
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0]        cyc_cnt,
  output logic [31:0]        ret_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [ALUOP_W-1:0] ALU_ADD = '0;
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_R   = ALUOP_W'(3);

  // The wait counter only needs to reach WDT-1: the next waiting cycle is the expiry.
  localparam int              WDT_W    = (WDT > 1) ? $clog2(WDT) : 1;
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'((WDT > 0) ? WDT - 1 : 0);

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_code;
  logic [1:0]       w_code;
  logic [WDT_W-1:0] r_wdt;

  logic w_is_r, w_r_ok, w_is_ori, w_is_addi, w_is_load, w_is_store, w_is_ldst;
  logic w_is_beq, w_legal, w_half, w_byte, w_wait, w_wdt_hit;

  // Instruction class decode (only meaningful once op is stable, from DECODE on)
  assign w_is_r     = (op == 6'h00);
  assign w_r_ok     = funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  assign w_is_ori   = (op == 6'h0D);
  assign w_is_addi  = (op == 6'h08);
  assign w_is_load  = op inside {6'h23, 6'h21, 6'h25, 6'h20, 6'h24};
  assign w_is_store = op inside {6'h2B, 6'h29, 6'h28};
  assign w_is_ldst  = w_is_load | w_is_store;
  assign w_is_beq   = (op == 6'h04);
  assign w_legal    = (w_is_r & w_r_ok) | w_is_ori | w_is_addi | w_is_ldst | w_is_beq | (op == 6'h02);
  assign w_half     = op inside {6'h21, 6'h25, 6'h29};
  assign w_byte     = op inside {6'h20, 6'h24, 6'h28};

  // mem_req is high exactly in FETCH and MEM; mem_rdy in the expiry cycle wins.
  assign w_wait    = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_rdy;
  assign w_wdt_hit = (WDT > 0) && w_wait && (r_wdt == WDT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_code  <= 2'b00;
      r_wdt   <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state != S_TRAP) && (w_next == S_TRAP)) r_code <= w_code;
      if (!w_wait || w_wdt_hit) r_wdt <= '0;
      else                      r_wdt <= r_wdt + 1'b1;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_code     = 2'b00;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_size   = 2'b00;
    mem_ext    = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'b00;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_srcA   = 1'b0;
    alu_srcB   = 2'b00;
    imm_ext    = 1'b0;
    alu_op     = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        mem_req  = 1'b1;
        alu_srcB = 2'b01;
        if (mem_rdy) begin
          ir_we  = 1'b1;
          pc_we  = 1'b1;
          w_next = S_DECODE;
        end else if (w_wdt_hit) begin
          w_next = S_TRAP;
          w_code = 2'b10;
        end
      end
      S_DECODE: begin
        alu_srcB = 2'b11;
        if (w_legal) begin
          w_next = S_EXEC;
        end else begin
          w_next = S_TRAP;
          w_code = 2'b01;
        end
      end
      S_EXEC: begin
        w_next = S_WB;
        if (w_is_r) begin
          alu_srcA = 1'b1;
          alu_op   = ALU_R;
        end else if (w_is_ori) begin
          alu_srcB = 2'b10;
          alu_op   = ALU_OR;
        end else if (w_is_addi || w_is_ldst) begin
          alu_srcB = 2'b10;
          imm_ext  = 1'b1;
          if (w_is_ldst) w_next = S_MEM;
        end else if (w_is_beq) begin
          alu_srcA = 1'b1;
          alu_op   = ALU_SUB;
          pc_src   = 2'b01;
          pc_we    = zero;
          w_next   = S_FETCH;
        end else begin
          // j is the only legal op left after DECODE screening
          pc_we  = 1'b1;
          pc_src = 2'b10;
          w_next = S_FETCH;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        mem_we   = w_is_store;
        mem_size = w_byte ? 2'b10 : (w_half ? 2'b01 : 2'b00);
        mem_ext  = (op == 6'h21) || (op == 6'h20);
        if (mem_rdy) begin
          w_next = w_is_store ? S_FETCH : S_WB;
        end else if (w_wdt_hit) begin
          w_next = S_TRAP;
          w_code = 2'b10;
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        reg_dst    = w_is_r;
        mem_to_reg = w_is_load;
        w_next     = S_FETCH;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_FETCH;
    endcase
    trap      = (r_state == S_TRAP);
    trap_code = r_code;
    state     = r_state;
    // Outputs go quiet the moment reset asserts, not at the next clock edge.
    if (!rst_n) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_size   = 2'b00;
      mem_ext    = 1'b0;
      iord       = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_src     = 2'b00;
      reg_we     = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_srcA   = 1'b0;
      alu_srcB   = 2'b00;
      imm_ext    = 1'b0;
      alu_op     = ALU_ADD;
      trap       = 1'b0;
      trap_code  = 2'b00;
      state      = 3'd0;
    end
  end

`ifdef MC_CTRL_PERF_EN
  logic [31:0] r_cyc;
  logic [31:0] r_ret;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc <= '0;
      r_ret <= '0;
    end else if (r_state != S_TRAP) begin
      r_cyc <= r_cyc + 32'd1;
      // An instruction retires when control returns to FETCH from a later phase
      if ((w_next == S_FETCH) && (r_state inside {S_EXEC, S_MEM, S_WB}))
        r_ret <= r_ret + 32'd1;
    end
  end

  assign cyc_cnt = r_cyc;
  assign ret_cnt = r_ret;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
module tb_mc_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_rdy = 1'b0;
  logic       mem_req, mem_we, mem_ext, iord, ir_we, pc_we, reg_we, reg_dst, mem_to_reg;
  logic       alu_srcA, imm_ext, trap;
  logic [1:0] mem_size, pc_src, alu_srcB, trap_code;
  logic [2:0] alu_op, state;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] cyc_cnt, ret_cnt;
`endif

  always #5 clk = ~clk;

  mc_ctrl #(.ALUOP_W(3), .WDT(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_rdy(mem_rdy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_ext(mem_ext),
    .iord(iord), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_srcA(alu_srcA), .alu_srcB(alu_srcB),
    .imm_ext(imm_ext), .alu_op(alu_op), .trap(trap), .trap_code(trap_code), .state(state)
`ifdef MC_CTRL_PERF_EN
    , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
  );

  typedef struct packed {
    logic [2:0] st;
    logic       req, we;
    logic [1:0] size;
    logic       ext, iord, ir_we, pc_we;
    logic [1:0] pc_src;
    logic       reg_we, reg_dst, m2r, srcA;
    logic [1:0] srcB;
    logic       imm_ext;
    logic [2:0] aop;
    logic       trap;
    logic [1:0] tc;
  } ctl_t;

  ctl_t obs;
  assign obs = {state, mem_req, mem_we, mem_size, mem_ext, iord, ir_we, pc_we, pc_src,
                reg_we, reg_dst, mem_to_reg, alu_srcA, alu_srcB, imm_ext, alu_op, trap, trap_code};

  int n_vec = 0;
  int n_err = 0;
  int m_cyc = 0;
  int m_ret = 0;
  logic [11:0] tbl [17];

  // Instruction class: 0 illegal, 1 R, 2 ori, 3 addi, 4 load, 5 store, 6 beq, 7 j
  function automatic int cls(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'h00: return (f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 || f == 6'h2A) ? 1 : 0;
      6'h0D: return 2;
      6'h08: return 3;
      6'h23, 6'h21, 6'h25, 6'h20, 6'h24: return 4;
      6'h2B, 6'h29, 6'h28: return 5;
      6'h04: return 6;
      6'h02: return 7;
      default: return 0;
    endcase
  endfunction

  // Expected control word for a phase (0 F, 1 D, 2 E, 3 M, 4 WB, 7 TRAP)
  function automatic ctl_t exp_ctl(input int ph, input logic [5:0] o, input logic [5:0] f,
                                   input logic z, input logic r, input logic [1:0] tc);
    ctl_t e;
    int c;
    e = '0;
    c = cls(o, f);
    case (ph)
      0: begin e.st = 3'd0; e.req = 1'b1; e.srcB = 2'b01; e.ir_we = r; e.pc_we = r; end
      1: begin e.st = 3'd1; e.srcB = 2'b11; end
      2: begin
        e.st = 3'd2;
        case (c)
          1: begin e.srcA = 1'b1; e.aop = 3'd3; end
          2: begin e.srcB = 2'b10; e.aop = 3'd2; end
          3, 4, 5: begin e.srcB = 2'b10; e.imm_ext = 1'b1; end
          6: begin e.srcA = 1'b1; e.aop = 3'd1; e.pc_src = 2'b01; e.pc_we = z; end
          7: begin e.pc_we = 1'b1; e.pc_src = 2'b10; end
          default: ;
        endcase
      end
      3: begin
        e.st = 3'd3; e.req = 1'b1; e.iord = 1'b1; e.we = (c == 5);
        case (o)
          6'h21, 6'h25, 6'h29: e.size = 2'b01;
          6'h20, 6'h24, 6'h28: e.size = 2'b10;
          default: e.size = 2'b00;
        endcase
        e.ext = (o == 6'h21) || (o == 6'h20);
      end
      4: begin e.st = 3'd4; e.reg_we = 1'b1; e.reg_dst = (c == 1); e.m2r = (c == 4); end
      default: begin e.st = 3'd7; e.trap = 1'b1; e.tc = tc; end
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // One cycle: drive at a negedge, check 1 time unit later, advance to the next negedge
  task automatic step(input string tag, input int ph, input logic [5:0] o, input logic [5:0] f,
                      input logic z, input logic r, input logic [1:0] tc);
    op = o; funct = f; zero = z; mem_rdy = r;
    #1;
    chk(tag, 32'(obs), 32'(exp_ctl(ph, o, f, z, r, tc)));
`ifdef MC_CTRL_PERF_EN
    chk({tag, " cyc"}, cyc_cnt, 32'(m_cyc));
    chk({tag, " ret"}, ret_cnt, 32'(m_ret));
`endif
    if (ph != 7) m_cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; mem_rdy = 1'($urandom); op = 6'($urandom);
    #1;
    chk("reset outputs", 32'(obs), 32'd0);
`ifdef MC_CTRL_PERF_EN
    chk("reset cyc", cyc_cnt, 32'd0);
    chk("reset ret", ret_cnt, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1; m_cyc = 0; m_ret = 0;
  endtask

  task automatic run_instr(input string nm, input logic [5:0] o, input logic [5:0] f,
                           input logic z, input int fw, input int mw);
    int c;
    int waits;
    int phs[$];
    c = cls(o, f);
    phs.push_back(0); phs.push_back(1);
    case (c)
      0: phs.push_back(7);
      1, 2, 3: begin phs.push_back(2); phs.push_back(4); end
      4: begin phs.push_back(2); phs.push_back(3); phs.push_back(4); end
      5: begin phs.push_back(2); phs.push_back(3); end
      default: phs.push_back(2);
    endcase
    foreach (phs[k]) begin
      waits = (phs[k] == 0) ? fw : ((phs[k] == 3) ? mw : 0);
      for (int w = 0; w <= waits; w++)
        step($sformatf("%s op%h ph%0d w%0d", nm, o, phs[k], w), phs[k], o, f, z,
             (phs[k] == 0 || phs[k] == 3) ? (w == waits) : 1'($urandom),
             (c == 0) ? 2'b01 : 2'b00);
    end
    if (c != 0) m_ret++;
  endtask

  task automatic trap_hold(input string nm, input logic [1:0] tc, input int n);
    for (int i = 0; i < n; i++)
      step($sformatf("%s hold%0d", nm, i), 7, 6'($urandom), 6'($urandom),
           1'($urandom), 1'($urandom), tc);
  endtask

  initial begin
    logic [5:0] o;
    logic [5:0] f;
    int idx;
    tbl = '{{6'h00, 6'h20}, {6'h00, 6'h22}, {6'h00, 6'h24}, {6'h00, 6'h25}, {6'h00, 6'h2A},
            {6'h0D, 6'h00}, {6'h08, 6'h00}, {6'h23, 6'h00}, {6'h21, 6'h00}, {6'h25, 6'h00},
            {6'h20, 6'h00}, {6'h24, 6'h00}, {6'h2B, 6'h00}, {6'h29, 6'h00}, {6'h28, 6'h00},
            {6'h04, 6'h00}, {6'h02, 6'h00}};
    @(negedge clk);
    do_reset();

    run_instr("R add", 6'h00, 6'h20, 1'b0, 0, 0);
    run_instr("lw 3 waits", 6'h23, 6'($urandom), 1'b0, 0, 3);
    run_instr("beq taken", 6'h04, 6'($urandom), 1'b1, 0, 0);
    run_instr("beq not taken", 6'h04, 6'($urandom), 1'b0, 0, 0);

    for (int i = 0; i < 60; i++) begin
      idx = $urandom_range(0, 16);
      o = tbl[idx][11:6];
      f = (o == 6'h00) ? tbl[idx][5:0] : 6'($urandom);
      run_instr($sformatf("rand%0d", i), o, f, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Four instructions of 4+5+3+4 cycles
    do_reset();
    run_instr("perf sb", 6'h28, 6'h00, 1'b0, 0, 0);
    run_instr("perf lhu", 6'h25, 6'h00, 1'b0, 0, 0);
    run_instr("perf j", 6'h02, 6'h00, 1'b0, 0, 0);
    run_instr("perf ori", 6'h0D, 6'h00, 1'b0, 0, 0);
`ifdef MC_CTRL_PERF_EN
    chk("perf cyc total", cyc_cnt, 32'd16);
    chk("perf ret total", ret_cnt, 32'd4);
`endif
    // Reset while a store is waiting in MEM
    step("midmem F", 0, 6'h28, 6'h00, 1'b0, 1'b1, 2'b00);
    step("midmem D", 1, 6'h28, 6'h00, 1'b0, 1'b0, 2'b00);
    step("midmem E", 2, 6'h28, 6'h00, 1'b0, 1'b0, 2'b00);
    step("midmem M", 3, 6'h28, 6'h00, 1'b0, 1'b0, 2'b00);
    do_reset();

    run_instr("illegal op3F", 6'h3F, 6'h00, 1'b0, 0, 0);
    trap_hold("illegal op3F", 2'b01, 4);
    do_reset();
    run_instr("illegal funct", 6'h00, 6'h21, 1'b0, 1, 0);
    trap_hold("illegal funct", 2'b01, 2);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      o = 6'h3E;
      for (int t = 0; t < 100; t++) begin
        o = 6'($urandom);
        if (cls(o, 6'h20) == 0) break;
      end
      if (cls(o, 6'h20) == 0) begin
        run_instr($sformatf("illegal rand%0d", i), o, 6'h20, 1'b0, 0, 0);
        trap_hold("illegal rand", 2'b01, 1);
        do_reset();
      end
    end

    // Watchdog in FETCH: four waiting cycles expire it
    for (int w = 0; w < 4; w++) step($sformatf("wdt fetch w%0d", w), 0, 6'h00, 6'h20, 1'b0, 1'b0, 2'b00);
    trap_hold("wdt fetch trap", 2'b10, 3);
    do_reset();
    // mem_rdy on the 4th cycle rescues both FETCH and MEM
    run_instr("wdt edge lw", 6'h23, 6'h00, 1'b0, 3, 3);
    run_instr("wdt edge sh", 6'h29, 6'h00, 1'b0, 3, 3);
    // Watchdog in MEM
    step("wdt mem F", 0, 6'h21, 6'h00, 1'b0, 1'b1, 2'b00);
    step("wdt mem D", 1, 6'h21, 6'h00, 1'b0, 1'b0, 2'b00);
    step("wdt mem E", 2, 6'h21, 6'h00, 1'b0, 1'b0, 2'b00);
    for (int w = 0; w < 4; w++) step($sformatf("wdt mem w%0d", w), 3, 6'h21, 6'h00, 1'b0, 1'b0, 2'b00);
    trap_hold("wdt mem trap", 2'b10, 2);
    do_reset();
    run_instr("after reset addi", 6'h08, 6'h15, 1'b0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
